// File: rtl/mul_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_seq_pkg
//  Description : Shared definitions for the sequential shift-add multiplier.
//                Holds the FSM state encoding, operand width and the number
//                of shift-add steps per multiply.
//  Revision    : 1.0  initial release
// ============================================================================
package mul_seq_pkg;

    localparam int MUL_SEQ_WIDTH  = 32;
    localparam int MUL_SEQ_CYCLES = 32;
    localparam int MUL_SEQ_CNT_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : mul_seq_pkg
`default_nettype wire

// File: rtl/mul_seq_add33.sv
`default_nettype none
// ============================================================================
//  Module      : mul_seq_add33
//  Description : Combinational 32+32 -> 33-bit adder used for the partial
//                product accumulation step of mul_seq.
//  Ports       : a_i   - accumulator high word
//                b_i   - multiplicand (or zero when the multiplier bit is 0)
//                sum_o - 33-bit sum including carry-out
//  Revision    : 1.0  initial release
// ============================================================================
module mul_seq_add33
    import mul_seq_pkg::*;
(
    input  logic [MUL_SEQ_WIDTH-1:0] a_i,
    input  logic [MUL_SEQ_WIDTH-1:0] b_i,
    output logic [MUL_SEQ_WIDTH:0]   sum_o
);

    assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule : mul_seq_add33
`default_nettype wire

// File: rtl/mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mul_seq
//  Description : Sequential 32x32 -> 64-bit shift-add multiplier.
//                IDLE accepts a request, RUN performs 32 shift-add steps and
//                then registers the result, DONE pulses done for one cycle.
//                Accept at edge N gives done in the cycle after edge N+33.
//  Options     : MUL_SEQ_SIGNED_EN - adds signed_op_i; signed operands are
//                converted to magnitudes on accept and the result negated
//                when the operand signs differ.
//  Ports       : clk, rst_n        - clock, asynchronous active-low reset
//                start_i, abort_i  - request / cancel in-flight multiply
//                a_i, b_i          - multiplicand / multiplier
//                signed_op_i       - two's-complement op (option only)
//                busy_o, done_o    - status (RUN/DONE), result-valid pulse
//                product_o         - 64-bit result, held until next accept
//                zero_flag_o       - product is zero
//                ovf32_flag_o      - product does not fit in 32 bits
//  Revision    : 1.0  initial release
// ============================================================================
module mul_seq
    import mul_seq_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [MUL_SEQ_WIDTH-1:0]   a_i,
    input  logic [MUL_SEQ_WIDTH-1:0]   b_i,
`ifdef MUL_SEQ_SIGNED_EN
    input  logic                       signed_op_i,
`endif
    output logic                       busy_o,
    output logic                       done_o,
    output logic [2*MUL_SEQ_WIDTH-1:0] product_o,
    output logic                       zero_flag_o,
    output logic                       ovf32_flag_o
);

    localparam int W = MUL_SEQ_WIDTH;

    state_e                   state_q;
    logic [MUL_SEQ_CNT_W-1:0] cnt_q;
    logic [W-1:0]             mcand_q;
    logic [W-1:0]             acc_hi_q;
    logic [W-1:0]             acc_lo_q;   // low product bits shift in from the top, multiplier out of bit 0
    logic                     neg_q;
    logic                     sgn_q;
    logic                     busy_q;
    logic                     done_q;
    logic [2*W-1:0]           product_q;
    logic                     zero_q;
    logic                     ovf_q;

    // ------------------------------------------------------------------
    // Operand conditioning on accept
    // ------------------------------------------------------------------
    logic [W-1:0] mcand_d;
    logic [W-1:0] mplier_d;
    logic         neg_d;
    logic         sgn_d;

    always_comb begin
        mcand_d  = a_i;
        mplier_d = b_i;
        neg_d    = 1'b0;
        sgn_d    = 1'b0;
`ifdef MUL_SEQ_SIGNED_EN
        if (signed_op_i) begin
            sgn_d = 1'b1;
            neg_d = a_i[W-1] ^ b_i[W-1];
            // 0x80000000 maps onto itself, which is the correct unsigned magnitude
            if (a_i[W-1]) mcand_d  = ~a_i + 1'b1;
            if (b_i[W-1]) mplier_d = ~b_i + 1'b1;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Shift-add step
    // ------------------------------------------------------------------
    logic [W-1:0] add_b;
    logic [W:0]   sum33;

    assign add_b = acc_lo_q[0] ? mcand_q : '0;

    mul_seq_add33 u_add33 (
        .a_i   (acc_hi_q),
        .b_i   (add_b),
        .sum_o (sum33)
    );

    // ------------------------------------------------------------------
    // Final result and flags, registered on the RUN->DONE edge
    // ------------------------------------------------------------------
    logic [2*W-1:0] raw_d;
    logic [2*W-1:0] product_d;
    logic           zero_d;
    logic           ovf_d;

    always_comb begin
        raw_d     = {acc_hi_q, acc_lo_q};
        product_d = neg_q ? (~raw_d + 64'd1) : raw_d;
        zero_d    = (product_d == '0);
        if (sgn_q) ovf_d = (product_d[2*W-1:W] != {W{product_d[W-1]}});
        else       ovf_d = (product_d[2*W-1:W] != '0);
    end

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            neg_q     <= 1'b0;
            sgn_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            zero_q    <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        mcand_q  <= mcand_d;
                        acc_lo_q <= mplier_d;
                        acc_hi_q <= '0;
                        cnt_q    <= '0;
                        neg_q    <= neg_d;
                        sgn_q    <= sgn_d;
                        busy_q   <= 1'b1;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort_i) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == MUL_SEQ_CNT_W'(MUL_SEQ_CYCLES)) begin
                        // All steps complete: accumulator holds the magnitude product
                        product_q <= product_d;
                        zero_q    <= zero_d;
                        ovf_q     <= ovf_d;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        acc_hi_q <= sum33[W:1];
                        acc_lo_q <= {sum33[0], acc_lo_q[W-1:1]};
                        cnt_q    <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign product_o    = product_q;
    assign zero_flag_o  = zero_q;
    assign ovf32_flag_o = ovf_q;

endmodule : mul_seq
`default_nettype wire

// File: tb/tb_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_seq
//  Description : Directed self-checking bench for mul_seq. Signed cases are
//                compiled in when MUL_SEQ_SIGNED_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] a;
    logic [31:0] b;
    logic        signed_op;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic        zero_flag;
    logic        ovf32_flag;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    mul_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .abort_i      (abort),
        .a_i          (a),
        .b_i          (b),
`ifdef MUL_SEQ_SIGNED_EN
        .signed_op_i  (signed_op),
`endif
        .busy_o       (busy),
        .done_o       (done),
        .product_o    (product),
        .zero_flag_o  (zero_flag),
        .ovf32_flag_o (ovf32_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits for done after an accept edge; returns edges from accept to done
    // (-1 on timeout). Optionally drives a stray start at RUN cycle inj.
    task automatic wait_done(input int inj, output int lat);
        lat = -1;
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            start = (c == inj);
            if (c == inj) begin
                a = 32'd9;
                b = 32'd9;
            end
            @(posedge clk); #1;
            if (done === 1'b1) lat = c;
        end
        start = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic sg,
                          input logic ab, input int inj, output int lat);
        a         = av;
        b         = bv;
        signed_op = sg;
        start     = 1'b1;
        abort     = ab;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        wait_done(inj, lat);
    endtask

    int lat;
    int d0;

    initial begin
        rst_n = 1'b1; start = 1'b0; abort = 1'b0;
        a = '0; b = '0; signed_op = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_zero", 64'(zero_flag), 64'd1);
        check("rst_ovf", 64'(ovf32_flag), 64'd0);
        #29 rst_n = 1'b1;
        @(posedge clk); #1;

        // 3*5
        run_op(32'd3, 32'd5, 1'b0, 1'b0, 0, lat);
        check("3x5_latency", 64'(lat), 64'd33);
        check("3x5_product", product, 64'd15);
        check("3x5_zero", 64'(zero_flag), 64'd0);
        check("3x5_ovf", 64'(ovf32_flag), 64'd0);
        check("3x5_busy_in_done", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check("3x5_done_one_cycle", 64'(done), 64'd0);
        check("3x5_busy_after", 64'(busy), 64'd0);

        // max unsigned
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, lat);
        check("max_latency", 64'(lat), 64'd33);
        check("max_product", product, 64'hFFFF_FFFE_0000_0001);
        check("max_ovf", 64'(ovf32_flag), 64'd1);
        check("max_zero", 64'(zero_flag), 64'd0);
        @(posedge clk); #1;

        // times zero with a stray start during RUN
        d0 = done_cnt;
        run_op(32'h1234_5678, 32'd0, 1'b0, 1'b0, 5, lat);
        check("zero_latency", 64'(lat), 64'd33);
        check("zero_product", product, 64'd0);
        check("zero_flag", 64'(zero_flag), 64'd1);
        check("zero_ovf", 64'(ovf32_flag), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        check("zero_no_queue_busy", 64'(busy), 64'd0);
        check("zero_one_done", 64'(done_cnt - d0), 64'd1);

        // 7*6 then abort at RUN cycle 10
        run_op(32'd7, 32'd6, 1'b0, 1'b0, 0, lat);
        check("7x6_product", product, 64'd42);
        @(posedge clk); #1;
        d0 = done_cnt;
        a = 32'd100; b = 32'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_product_kept", product, 64'd42);
        check("abort_zero_kept", 64'(zero_flag), 64'd0);

        // start and abort together in IDLE: start wins
        run_op(32'd2, 32'd3, 1'b0, 1'b1, 0, lat);
        check("startabort_latency", 64'(lat), 64'd33);
        check("startabort_product", product, 64'd6);

        // start during DONE ignored, accepted in following IDLE cycle
        a = 32'd2; b = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        check("done_start_ignored", 64'(busy), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check("idle_start_accepted", 64'(busy), 64'd1);
        wait_done(0, lat);
        check("idle_start_latency", 64'(lat), 64'd33);
        check("idle_start_product", product, 64'd4);
        @(posedge clk); #1;

        // reset at RUN cycle 20
        d0 = done_cnt;
        a = 32'd5; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_product", product, 64'd0);
        check("midrst_zero", 64'(zero_flag), 64'd1);
        check("midrst_done", 64'(done), 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (40) @(posedge clk);
        #1;
        check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        run_op(32'd4, 32'd4, 1'b0, 1'b0, 0, lat);
        check("postrst_latency", 64'(lat), 64'd33);
        check("postrst_product", product, 64'd16);
        @(posedge clk); #1;

`ifdef MUL_SEQ_SIGNED_EN
        run_op(32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0, 0, lat);
        check("sgn_latency", 64'(lat), 64'd33);
        check("sgn_product", product, 64'hFFFF_FFFF_FFFF_FFEB);
        check("sgn_ovf", 64'(ovf32_flag), 64'd0);
        @(posedge clk); #1;
        run_op(32'hFFFF_FFFD, 32'hFFFF_FFF9, 1'b1, 1'b0, 0, lat);
        check("sgn_negneg_product", product, 64'd21);
        @(posedge clk); #1;
        run_op(32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, 0, lat);
        check("sgnoff_product", product, 64'h0000_0006_FFFF_FFEB);
        check("sgnoff_ovf", 64'(ovf32_flag), 64'd1);
        @(posedge clk); #1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mul_seq
`default_nettype wire
